// File: rtl/data_sync_launch_pkg.sv
// Shared definitions for the launcher and the destination-side bus synchronizer.
package data_sync_launch_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StReq     = 2'd1,
      StRelease = 2'd2
   } sync_state_e;

   localparam int unsigned NumStagesMin = 2;
   localparam int unsigned NumStagesMax = 4;

endpackage

// File: rtl/data_sync_launch_ack_sync_ff.sv
// NUM_STAGES flop synchronizer, async active-low reset to 0.
// Also used on the destination side for bus_enable.
module ack_sync_ff
   import data_sync_launch_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   if (NUM_STAGES < NumStagesMin || NUM_STAGES > NumStagesMax) begin : g_bad_stages
      $error("ack_sync_ff: NUM_STAGES out of range");
   end

   logic [NUM_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[NUM_STAGES-2:0], d};
      end
   end

   assign q = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_launch.sv
// Source-domain launcher: holds a word on unsync_bus and runs a 4-phase
// level req/ack handshake with the destination-side synchronizer.
module data_sync_launch
   import data_sync_launch_pkg::*;
#(
   parameter int unsigned BUS_WIDTH  = 8,
   parameter int unsigned NUM_STAGES = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 ack_async,
   output logic [BUS_WIDTH-1:0] unsync_bus,
   output logic                 bus_enable,
   output logic                 busy
);

   sync_state_e          state_q, state_d;
   logic [BUS_WIDTH-1:0] data_q, data_d;
   logic                 enable_q, enable_d;
   logic                 ack_sync;

   ack_sync_ff #(
      .NUM_STAGES(NUM_STAGES)
   ) u_ack_sync (
      .clk  (CLK),
      .rst_n(RST),
      .d    (ack_async),
      .q    (ack_sync)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= StIdle;
         data_q   <= '0;
         enable_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         enable_q <= enable_d;
      end
   end

   // in_ready/busy depend on state only; the bus register loads only on an IDLE accept.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      enable_d = enable_q;
      in_ready = 1'b0;
      busy     = 1'b1;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               data_d   = in_data;
               enable_d = 1'b1;
               state_d  = StReq;
            end
         end
         StReq: begin
            if (ack_sync) begin
               enable_d = 1'b0;
               state_d  = StRelease;
            end
         end
         StRelease: begin
            if (!ack_sync) begin
               state_d = StIdle;
            end
         end
         default: begin
            enable_d = 1'b0;
            state_d  = StIdle;
         end
      endcase
   end

   assign unsync_bus = data_q;
   assign bus_enable = enable_q;

endmodule

// File: tb/tb_data_sync_launch.sv
// Directed bench for data_sync_launch: two instances (2-stage/8-bit, 3-stage/16-bit),
// with a per-instance scoreboard of accepted words and bus-hold monitor.
module tb_data_sync_launch;

   localparam int unsigned NsA = 2;
   localparam int unsigned NsB = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [7:0]  a_data, a_bus;
   logic        a_valid, a_ready, a_ack, a_en, a_busy;
   logic [15:0] b_data, b_bus;
   logic        b_valid, b_ready, b_ack, b_en, b_busy;

   int vectors = 0;
   int miscompares = 0;
   int a_accepts = 0;
   int b_accepts = 0;

   logic [7:0]  a_q[$];
   logic [15:0] b_q[$];
   logic [7:0]  a_word = '0;
   logic [15:0] b_word = '0;
   logic        a_prev = 1'b0;
   logic        b_prev = 1'b0;

   always #5 clk = ~clk;

   data_sync_launch #(
      .BUS_WIDTH (8),
      .NUM_STAGES(NsA)
   ) u_dut_a (
      .CLK       (clk),
      .RST       (rst_n),
      .in_data   (a_data),
      .in_valid  (a_valid),
      .in_ready  (a_ready),
      .ack_async (a_ack),
      .unsync_bus(a_bus),
      .bus_enable(a_en),
      .busy      (a_busy)
   );

   data_sync_launch #(
      .BUS_WIDTH (16),
      .NUM_STAGES(NsB)
   ) u_dut_b (
      .CLK       (clk),
      .RST       (rst_n),
      .in_data   (b_data),
      .in_valid  (b_valid),
      .in_ready  (b_ready),
      .ack_async (b_ack),
      .unsync_bus(b_bus),
      .bus_enable(b_en),
      .busy      (b_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return a_en;
         1:       return a_ready;
         2:       return b_en;
         3:       return b_ready;
         default: return 1'bx;
      endcase
   endfunction

   // Count edges until the selected output reaches v (bounded); optionally churn in_data.
   task automatic wait_sig(input int sel, input logic v, input bit churn, output int n);
      n = 0;
      do begin
         if (churn) begin
            a_data = 8'($urandom);
            b_data = 16'($urandom);
         end
         tick();
         n++;
      end while (sig(sel) !== v && n < 40);
   endtask

   // Scoreboard: pop on each bus_enable rise; otherwise the bus must hold the last word.
   always begin
      tick();
      if (!rst_n) begin
         a_word = '0;
         a_prev = 1'b0;
      end else begin
         if (a_en && !a_prev) begin
            a_accepts++;
            if (a_q.size() == 0) chk("a_unexpected_accept", 32'(a_bus), 32'hFFFF_FFFF);
            else begin
               a_word = a_q.pop_front();
               chk("a_accept_word", a_bus, a_word);
            end
         end else chk("a_bus_hold", a_bus, a_word);
         a_prev = a_en;
      end
   end

   always begin
      tick();
      if (!rst_n) begin
         b_word = '0;
         b_prev = 1'b0;
      end else begin
         if (b_en && !b_prev) begin
            b_accepts++;
            if (b_q.size() == 0) chk("b_unexpected_accept", 32'(b_bus), 32'hFFFF_FFFF);
            else begin
               b_word = b_q.pop_front();
               chk("b_accept_word", b_bus, b_word);
            end
         end else chk("b_bus_hold", b_bus, b_word);
         b_prev = b_en;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1);
   end

   initial begin
      int n;
      int acc0;
      a_valid = 1'b0; a_data = '0; a_ack = 1'b0;
      b_valid = 1'b0; b_data = '0; b_ack = 1'b0;

      // Reset values
      tick(); tick();
      chk("a_rst_ready", a_ready, 1'b1);
      chk("a_rst_busy", a_busy, 1'b0);
      chk("a_rst_en", a_en, 1'b0);
      chk("a_rst_bus", a_bus, 8'h00);
      chk("b_rst_ready", b_ready, 1'b1);
      chk("b_rst_bus", b_bus, 16'h0000);
      rst_n = 1'b1;
      tick();

      // Single transfer 0x3C with in_data churn while in REQ
      a_data = 8'h3C; a_valid = 1'b1; a_q.push_back(8'h3C);
      tick();
      chk("a_accept_en", a_en, 1'b1);
      chk("a_accept_bus", a_bus, 8'h3C);
      chk("a_accept_ready", a_ready, 1'b0);
      chk("a_accept_busy", a_busy, 1'b1);
      for (int i = 0; i < 3; i++) begin
         a_data = 8'($urandom);
         tick();
         chk("a_churn_ready", a_ready, 1'b0);
      end
      a_ack = 1'b1;
      wait_sig(0, 1'b0, 1'b1, n);
      chk("a_en_fall_lat", n, NsA + 1);
      a_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("a_release_ready", a_ready, 1'b0);
      end
      a_ack = 1'b0;
      wait_sig(1, 1'b1, 1'b0, n);
      chk("a_ready_lat", n, NsA + 1);
      chk("a_done_bus", a_bus, 8'h3C);
      chk("a_done_busy", a_busy, 1'b0);

      // Reset asserted mid-REQ holding 0xA5
      a_data = 8'hA5; a_valid = 1'b1; a_q.push_back(8'hA5);
      tick();
      a_valid = 1'b0;
      chk("a_a5_en", a_en, 1'b1);
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      chk("a_midrst_en", a_en, 1'b0);
      chk("a_midrst_bus", a_bus, 8'h00);
      chk("a_midrst_ready", a_ready, 1'b1);
      chk("a_midrst_busy", a_busy, 1'b0);
      tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("a_postrst_ready", a_ready, 1'b1);
      chk("a_postrst_en", a_en, 1'b0);

      // Ack already high at accept
      a_data = 8'h77; a_valid = 1'b1; a_ack = 1'b1; a_q.push_back(8'h77);
      wait_sig(0, 1'b1, 1'b0, n);
      a_valid = 1'b0;
      chk("a_ackhi_accept_lat", n, 1);
      wait_sig(0, 1'b0, 1'b0, n);
      chk("a_ackhi_req_lat", n, NsA);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("a_ackhi_hold_ready", a_ready, 1'b0);
         chk("a_ackhi_hold_busy", a_busy, 1'b1);
      end
      a_ack = 1'b0;
      wait_sig(1, 1'b1, 1'b0, n);
      chk("a_ackhi_ready_lat", n, NsA + 1);
      chk("a_ackhi_bus", a_bus, 8'h77);

      // Back-to-back with in_valid held: 0x01, 0x02, 0x03
      acc0 = a_accepts;
      a_valid = 1'b1;
      for (int w = 1; w <= 3; w++) begin
         a_data = 8'(w);
         a_q.push_back(8'(w));
         wait_sig(0, 1'b1, 1'b0, n);
         if (w == 3) a_valid = 1'b0;
         chk("a_b2b_accept_lat", n, 1);
         tick(); tick();
         a_ack = 1'b1;
         wait_sig(0, 1'b0, 1'b0, n);
         chk("a_b2b_en_fall_lat", n, NsA + 1);
         tick();
         a_ack = 1'b0;
         wait_sig(1, 1'b1, 1'b0, n);
         chk("a_b2b_ready_lat", n, NsA + 1);
      end
      tick(); tick(); tick();
      chk("a_b2b_accepts", a_accepts - acc0, 3);
      chk("a_b2b_last_bus", a_bus, 8'h03);
      chk("a_queue_empty", a_q.size(), 0);

      // Wide instance, 3 stages: 0xBEEF
      b_data = 16'hBEEF; b_valid = 1'b1; b_q.push_back(16'hBEEF);
      wait_sig(2, 1'b1, 1'b0, n);
      b_valid = 1'b0;
      chk("b_accept_lat", n, 1);
      chk("b_accept_bus", b_bus, 16'hBEEF);
      for (int i = 0; i < 3; i++) begin
         b_data = 16'($urandom);
         tick();
      end
      b_ack = 1'b1;
      wait_sig(2, 1'b0, 1'b1, n);
      chk("b_en_fall_lat", n, NsB + 1);
      for (int i = 0; i < 3; i++) tick();
      b_ack = 1'b0;
      wait_sig(3, 1'b1, 1'b0, n);
      chk("b_ready_lat", n, NsB + 1);
      chk("b_done_bus", b_bus, 16'hBEEF);
      tick();
      chk("b_accepts", b_accepts, 1);
      chk("b_queue_empty", b_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/data_sync_launch.md
# data_sync_launch

Source-domain launcher for the multi-bit bus synchronizer. It accepts a word through a valid/ready handshake and presents it on `unsync_bus`, holding it stable for the whole crossing. It raises `bus_enable` as a level-mode request and releases it only after the destination returns an acknowledge through a built-in flop synchronizer. This guarantees the destination's enable-synchronizer/pulse path never samples a changing bus. It sits in the transmitting clock domain, facing the destination-side bus synchronizer.

## Interface
- `BUS_WIDTH`, 8: data word width.
- `NUM_STAGES`, 2: flops in the ack synchronizer; legal range 2..4.

- `CLK` in 1: source-domain clock.
- `RST` in 1: reset. Asynchronous assert, active-low; all flops clear on `RST`=0.
- `in_data` in `BUS_WIDTH`: word to send.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: launcher can accept a word.
- `ack_async` in 1: level acknowledge from the destination domain, asynchronous to `CLK`.
- `unsync_bus` out `BUS_WIDTH`: registered held word toward the destination.
- `bus_enable` out 1: registered request level toward the destination.
- `busy` out 1: high in any state other than IDLE.

## Operation
- The block runs a 4-phase req/ack FSM with states IDLE, REQ, RELEASE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`=1 at an edge, `in_data` is captured into `unsync_bus`, `bus_enable` is set to 1, and the FSM moves to REQ.
- **REQ**
  - `in_ready`=0. `unsync_bus` and `bus_enable` are frozen.
  - When `ack_sync`=1, `bus_enable` is cleared and the FSM moves to RELEASE.
- **RELEASE**
  - `in_ready`=0. `unsync_bus` is still held.
  - When `ack_sync`=0, the FSM moves to IDLE.
- `ack_sync` is the last stage of the `NUM_STAGES`-flop synchronizer on `ack_async`. The FSM never reads `ack_async` directly.
- `unsync_bus` changes only on an IDLE accept. It keeps the last word after a transfer completes. It is never driven combinationally.
- `in_ready` and `busy` are decoded from state only, with no input-to-output combinational path.
- If `ack_async` is already 1 while in IDLE (a protocol violation), the accept still happens normally. REQ then exits as soon as `ack_sync`=1, which can be the next edge. No error flag.
- If `ack_sync` drops while in REQ (a glitch or violation), the FSM stays in REQ.
- Reset mid-transfer: state goes to IDLE, `bus_enable`=0, `unsync_bus`=0, and all synchronizer flops are cleared. The destination must tolerate the request dropping without an ack.

## Timing
- Reset values:
  - `in_ready`=1, `busy`=0, `bus_enable`=0, `unsync_bus`=0, state=IDLE.
- Accept at edge k: `bus_enable`=1 and the new `unsync_bus` both appear after edge k, in the same cycle.
- Ack rise: if `ack_async` rises before edge m, `ack_sync`=1 after edge m+`NUM_STAGES`-1. `bus_enable`=0 after the next edge.
- Ack fall: returns to IDLE one edge after `ack_sync` falls. `in_ready`=1 in that same cycle.
- Minimum transfer period, with an immediate destination ack and `NUM_STAGES`=2: 2 + 2·`NUM_STAGES` cycles plus destination latency.
- Back-to-back: a new accept is possible on the first IDLE cycle. There is no bubble beyond the FSM.

## Structure
- Shared package holds:
  - the state enum (IDLE, REQ, RELEASE);
  - the `NUM_STAGES` legal-range constants.
- The package is shared with the destination-side synchronizer.
- One sub-module, `ack_sync_ff`: a parameterized `NUM_STAGES` flop synchronizer with active-low asynchronous reset to 0. It is reusable by the destination side for `bus_enable`.
- Top level contains the FSM and the data holding register.
- Estimated size about 150 RTL lines.

## Test plan
- **Reset:** assert `RST`=0 mid-REQ holding 0xA5 -> `bus_enable`=0, `unsync_bus`=0x00, `in_ready`=1 immediately; FSM stays IDLE after release.
- **Single transfer:** `in_valid` with 0x3C; model the destination acking 3 cycles after `bus_enable` and dropping ack 3 cycles after `bus_enable` falls.
  - `unsync_bus`=0x3C held stable throughout.
  - `bus_enable` falls exactly `NUM_STAGES`+1 edges after the ack rises.
  - `in_ready` returns exactly `NUM_STAGES`+1 edges after the ack falls.
- **Back-to-back:** `in_valid` held with 0x01, 0x02, 0x03 -> exactly three accepts. Each word is stable from its accept until the next accept. No accept occurs while `busy`=1.
- **Input churn while busy:** change `in_data` every cycle in REQ/RELEASE -> `unsync_bus` unchanged; `in_ready`=0.
- **Ack high at accept:** tie `ack_async`=1 and send 0x77 -> REQ is left `NUM_STAGES` edges later. The FSM remains in RELEASE until ack is released, then returns to IDLE.
- **Parameter sweep:** `NUM_STAGES`=3, `BUS_WIDTH`=16, send 0xBEEF -> latencies scale with `NUM_STAGES` and full-width data is held.
